// File: rtl/multicycle_control_fsm_if.sv
// Control bus between the multicycle control FSM and its datapath.
//
// Signals:
//   opcode, mem_ready            datapath -> controller (instruction field, memory handshake)
//   PCWrite .. PCSource          controller -> datapath (enables and mux selects)
//   state_dbg, illegal_op,       controller -> observers (debug state, sticky illegal flag,
//   instr_count                  retired-instruction count)
//
// Modports:
//   master  the control FSM
//   slave   the datapath / environment
interface multicycle_control_fsm_if #(
    parameter int unsigned CNT_WIDTH = 32
);
    logic [5:0]           opcode;
    logic                 mem_ready;

    logic                 PCWrite;
    logic                 PCWriteCond;
    logic                 IorD;
    logic                 MemRead;
    logic                 MemWrite;
    logic                 MemtoReg;
    logic                 IRWrite;
    logic                 RegWrite;
    logic                 RegDst;
    logic                 ALUSrcA;
    logic [1:0]           ALUSrcB;
    logic [1:0]           ALUOp;
    logic [1:0]           PCSource;

    logic [3:0]           state_dbg;
    logic                 illegal_op;
    logic [CNT_WIDTH-1:0] instr_count;

    modport master (
        input  opcode,
        input  mem_ready,
        output PCWrite,
        output PCWriteCond,
        output IorD,
        output MemRead,
        output MemWrite,
        output MemtoReg,
        output IRWrite,
        output RegWrite,
        output RegDst,
        output ALUSrcA,
        output ALUSrcB,
        output ALUOp,
        output PCSource,
        output state_dbg,
        output illegal_op,
        output instr_count
    );

    modport slave (
        output opcode,
        output mem_ready,
        input  PCWrite,
        input  PCWriteCond,
        input  IorD,
        input  MemRead,
        input  MemWrite,
        input  MemtoReg,
        input  IRWrite,
        input  RegWrite,
        input  RegDst,
        input  ALUSrcA,
        input  ALUSrcB,
        input  ALUOp,
        input  PCSource,
        input  state_dbg,
        input  illegal_op,
        input  instr_count
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Main control state machine for a multicycle MIPS-style datapath.
//
// Sequences each instruction through fetch, decode and the opcode-specific execute,
// memory and write-back steps. Memory accesses (fetch, load, store) stall on mem_ready.
// Counts retired instructions and keeps a sticky flag for undefined opcodes.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset (0 = in reset)
//   bus    control bus (master side): opcode/mem_ready in, datapath controls and
//          state_dbg/illegal_op/instr_count out
module multicycle_control_fsm #(
    parameter int unsigned CNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    multicycle_control_fsm_if.master bus
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAddr  = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecute  = 4'd6,
        StRWb      = 4'd7,
        StBranch   = 4'd8,
        StJump     = 4'd9,
        StAddiExec = 4'd10,
        StAddiWb   = 4'd11
    } state_e;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpJ     = 6'b000010;
    localparam logic [5:0] OpAddi  = 6'b001000;

    state_e               state_q, state_d;
    logic                 illegal_q, illegal_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    // Asserted on the cycle an instruction completes and control returns to fetch.
    logic                 retire;
    logic                 set_illegal;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;

        case (state_q)
            StFetch: begin
                if (bus.mem_ready) begin
                    state_d = StDecode;
                end
            end

            StDecode: begin
                case (bus.opcode)
                    OpRtype:     state_d = StExecute;
                    OpLw, OpSw:  state_d = StMemAddr;
                    OpBeq:       state_d = StBranch;
                    OpJ:         state_d = StJump;
                    OpAddi:      state_d = StAddiExec;
                    default: begin
                        // Undefined opcode: abandon without retiring.
                        state_d     = StFetch;
                        set_illegal = 1'b1;
                    end
                endcase
            end

            // opcode is still valid here: the IR only loads during fetch.
            StMemAddr: begin
                state_d = (bus.opcode == OpLw) ? StMemRead : StMemWrite;
            end

            StMemRead: begin
                if (bus.mem_ready) begin
                    state_d = StMemWb;
                end
            end

            StMemWrite: begin
                if (bus.mem_ready) begin
                    state_d = StFetch;
                    retire  = 1'b1;
                end
            end

            StExecute:  state_d = StRWb;
            StAddiExec: state_d = StAddiWb;

            StMemWb, StRWb, StBranch, StJump, StAddiWb: begin
                state_d = StFetch;
                retire  = 1'b1;
            end

            // Unused codes recover to fetch.
            default: state_d = StFetch;
        endcase
    end

    assign illegal_d = illegal_q | set_illegal;
    assign cnt_d     = retire ? cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1} : cnt_q;

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StFetch;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Output decode (Moore, except IRWrite/PCWrite in fetch)
    // ------------------------------------------------------------------
    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.PCSource    = 2'b00;

        case (state_q)
            StFetch: begin
                // PC <= PC + 4 and IR load happen together when the fetch completes.
                // Gated by reset so nothing is loaded while the machine is held.
                bus.MemRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.IRWrite = bus.mem_ready & reset;
                bus.PCWrite = bus.mem_ready & reset;
            end

            StDecode: begin
                // Precompute the branch target while registers are read.
                bus.ALUSrcB = 2'b11;
            end

            StMemAddr, StAddiExec: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
            end

            StMemRead: begin
                bus.MemRead = 1'b1;
                bus.IorD    = 1'b1;
            end

            StMemWb: begin
                bus.RegWrite = 1'b1;
                bus.MemtoReg = 1'b1;
            end

            StMemWrite: begin
                bus.MemWrite = 1'b1;
                bus.IorD     = 1'b1;
            end

            StExecute: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUOp   = 2'b10;
            end

            StRWb: begin
                bus.RegWrite = 1'b1;
                bus.RegDst   = 1'b1;
            end

            StBranch: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUOp       = 2'b01;
                bus.PCWriteCond = 1'b1;
                bus.PCSource    = 2'b01;
            end

            StJump: begin
                bus.PCWrite  = 1'b1;
                bus.PCSource = 2'b10;
            end

            StAddiWb: begin
                bus.RegWrite = 1'b1;
            end

            default: ;
        endcase
    end

    assign bus.state_dbg   = state_q;
    assign bus.illegal_op  = illegal_q;
    assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. The reference model works per
// instruction: it lists the state codes an opcode walks through and stretches the
// memory-handshake steps by randomized stall counts.
module tb_multicycle_control_fsm;

    localparam int unsigned CW = 32;

    typedef struct packed {
        logic       pcw;
        logic       pcwc;
        logic       iord;
        logic       mrd;
        logic       mwr;
        logic       m2r;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       srca;
        logic [1:0] srcb;
        logic [1:0] aluop;
        logic [1:0] pcsrc;
    } ctrl_t;

    typedef struct packed {
        logic [3:0]    st;
        ctrl_t         c;
        logic          ill;
        logic [CW-1:0] cnt;
    } snap_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    multicycle_control_fsm_if #(.CNT_WIDTH(CW)) bus ();

    multicycle_control_fsm #(.CNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int            checks   = 0;
    int            failures = 0;
    logic          m_ill    = 1'b0;
    logic [CW-1:0] m_cnt    = '0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic bit is_legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    endfunction

    // Steps an instruction visits, by state code.
    function automatic void build_path(input logic [5:0] op, output int p[$]);
        p = {};
        case (op)
            6'b000000: p = {0, 1, 6, 7};
            6'b100011: p = {0, 1, 2, 3, 4};
            6'b101011: p = {0, 1, 2, 5};
            6'b000100: p = {0, 1, 8};
            6'b000010: p = {0, 1, 9};
            6'b001000: p = {0, 1, 10, 11};
            default:   p = {0, 1};
        endcase
    endfunction

    // Control values each step must present.
    function automatic ctrl_t exp_ctrl(input int s, input logic mr);
        ctrl_t c;
        c = '0;
        case (s)
            0: begin c.mrd = 1; c.srcb = 2'b01; c.irw = mr; c.pcw = mr; end
            1: c.srcb = 2'b11;
            2, 10: begin c.srca = 1; c.srcb = 2'b10; end
            3: begin c.mrd = 1; c.iord = 1; end
            4: begin c.rw = 1; c.m2r = 1; end
            5: begin c.mwr = 1; c.iord = 1; end
            6: begin c.srca = 1; c.aluop = 2'b10; end
            7: begin c.rw = 1; c.rdst = 1; end
            8: begin c.srca = 1; c.aluop = 2'b01; c.pcwc = 1; c.pcsrc = 2'b01; end
            9: begin c.pcw = 1; c.pcsrc = 2'b10; end
            11: c.rw = 1;
            default: ;
        endcase
        return c;
    endfunction

    function automatic snap_t observe();
        snap_t o;
        o.st      = bus.state_dbg;
        o.c.pcw   = bus.PCWrite;
        o.c.pcwc  = bus.PCWriteCond;
        o.c.iord  = bus.IorD;
        o.c.mrd   = bus.MemRead;
        o.c.mwr   = bus.MemWrite;
        o.c.m2r   = bus.MemtoReg;
        o.c.irw   = bus.IRWrite;
        o.c.rw    = bus.RegWrite;
        o.c.rdst  = bus.RegDst;
        o.c.srca  = bus.ALUSrcA;
        o.c.srcb  = bus.ALUSrcB;
        o.c.aluop = bus.ALUOp;
        o.c.pcsrc = bus.PCSource;
        o.ill     = bus.illegal_op;
        o.cnt     = bus.instr_count;
        return o;
    endfunction

    // Runs one instruction from fetch. Stall counts: <0 picks 0..3 at random.
    // abort_at >= 0 pulls reset in that step and abandons the instruction.
    task automatic run_instr(input string name, input logic [5:0] op, input int fwait,
                             input int mwait, input int abort_at);
        int    path[$];
        int    waits;
        logic  mr;
        snap_t got, exp;
        build_path(op, path);
        bus.opcode = op;
        foreach (path[i]) begin
            int s;
            bit stall_step;
            s          = path[i];
            stall_step = (s == 0) || (s == 3) || (s == 5);
            waits      = 0;
            if (s == 0) waits = (fwait < 0) ? int'($urandom_range(0, 3)) : fwait;
            else if (stall_step) waits = (mwait < 0) ? int'($urandom_range(0, 3)) : mwait;
            for (int w = 0; w <= waits; w++) begin
                mr = stall_step ? (w == waits) : 1'($urandom_range(0, 1));
                bus.mem_ready = mr;
                #1;
                got     = observe();
                exp.st  = 4'(s);
                exp.c   = exp_ctrl(s, mr);
                exp.ill = m_ill;
                exp.cnt = m_cnt;
                checks++;
                if (got !== exp) begin
                    failures++;
                    $display("FAIL %s op=%b step=%0d: got st=%0d ctrl=%h ill=%b cnt=%0d, expected st=%0d ctrl=%h ill=%b cnt=%0d",
                             name, op, i, got.st, got.c, got.ill, got.cnt,
                             exp.st, exp.c, exp.ill, exp.cnt);
                end
                if (s == abort_at && w == waits) begin
                    bus.mem_ready = 1'b1;
                    reset = 1'b0;
                    #1;
                    got     = observe();
                    exp.st  = 4'd0;
                    exp.c   = exp_ctrl(0, 1'b0);
                    exp.ill = 1'b0;
                    exp.cnt = '0;
                    checks++;
                    if (got !== exp) begin
                        failures++;
                        $display("FAIL %s async_reset: got st=%0d ctrl=%h ill=%b cnt=%0d, expected st=%0d ctrl=%h ill=%b cnt=%0d",
                                 name, got.st, got.c, got.ill, got.cnt,
                                 exp.st, exp.c, exp.ill, exp.cnt);
                    end
                    m_cnt = '0;
                    m_ill = 1'b0;
                    @(posedge clk);
                    #1;
                    bus.mem_ready = 1'b0;
                    #2;
                    reset = 1'b1;
                    @(posedge clk);
                    #1;
                    return;
                end
                @(posedge clk);
                #1;
            end
        end
        if (is_legal(op)) m_cnt = m_cnt + 1;
        else m_ill = 1'b1;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        snap_t got, exp;
        reset         = 1'b0;
        bus.opcode    = 6'b000000;
        bus.mem_ready = 1'b1;
        #3;
        exp.st  = 4'd0;
        exp.c   = exp_ctrl(0, 1'b0);
        exp.ill = 1'b0;
        exp.cnt = '0;
        for (int k = 0; k < 2; k++) begin
            got = observe();
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL reset_state[%0d]: got st=%0d ctrl=%h ill=%b cnt=%0d, expected st=%0d ctrl=%h ill=%b cnt=%0d",
                         k, got.st, got.c, got.ill, got.cnt, exp.st, exp.c, exp.ill, exp.cnt);
            end
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_rtype();
        run_instr("rtype", 6'b000000, 0, 0, -1);
    endtask

    task automatic test_lw_wait();
        run_instr("lw_wait", 6'b100011, 0, 3, -1);
    endtask

    task automatic test_back_to_back();
        run_instr("b2b_sw", 6'b101011, 0, 0, -1);
        run_instr("b2b_beq", 6'b000100, 0, 0, -1);
        run_instr("b2b_j", 6'b000010, 0, 0, -1);
    endtask

    task automatic test_fetch_stall();
        run_instr("fetch_stall", 6'b001000, 5, 0, -1);
    endtask

    task automatic test_illegal();
        run_instr("illegal", 6'b111111, 0, 0, -1);
        run_instr("after_illegal_r", 6'b000000, 0, 0, -1);
        run_instr("after_illegal_lw", 6'b100011, -1, -1, -1);
    endtask

    task automatic test_reset_mid_lw();
        run_instr("reset_mid_lw", 6'b100011, 0, 0, 4);
        run_instr("resume", 6'b000000, 0, 0, -1);
        run_instr("resume_sw", 6'b101011, -1, -1, -1);
    endtask

    task automatic test_random();
        logic [5:0] ops[6];
        logic [5:0] op;
        ops = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
        for (int n = 0; n < 40; n++) begin
            int pick;
            pick = int'($urandom_range(0, 6));
            op   = (pick < 6) ? ops[pick] : 6'($urandom);
            run_instr("random", op, -1, -1, -1);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back();
        test_fetch_stall();
        test_illegal();
        test_reset_mid_lw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Main control state machine for the multicycle datapath.
- Consumes the opcode field (bits 31:26) held by the instruction register.
- Drives IRWrite into the instruction register, RegWrite into the register file, plus all PC, memory, ALU and mux selects.
- Inserts wait states on a memory ready handshake; counts retired instructions and flags illegal opcodes.

Parameters:
- CNT_WIDTH, 32, width of retired-instruction counter instr_count.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- opcode  input  6  instruction bits 31:26 from instruction register.
- mem_ready  input  1  memory completes the current read/write this cycle.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified externally by ALU zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALU out.
- MemRead  output  1  memory read request.
- MemWrite  output  1  memory write request.
- MemtoReg  output  1  register write data select: 1 = memory data reg.
- IRWrite  output  1  instruction register load enable.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  write register select: 1 = rd, 0 = rt.
- ALUSrcA  output  1  0 = PC, 1 = reg A.
- ALUSrcB  output  2  00 = reg B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm shifted left 2.
- ALUOp  output  2  00 = add, 01 = subtract, 10 = use funct field.
- PCSource  output  2  00 = ALU result, 01 = ALU out reg, 10 = jump target.
- state_dbg  output  4  current state encoding.
- illegal_op  output  1  sticky flag: an undefined opcode was decoded.
- instr_count  output  CNT_WIDTH  retired-instruction count.

Behaviour:
- Supported opcodes:
  - R-type 000000
  - lw 100011
  - sw 101011
  - beq 000100
  - j 000010
  - addi 001000
  - anything else is illegal.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_READ 3, MEM_WB 4, MEM_WRITE 5, EXECUTE 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EXEC 10, ADDI_WB 11. Codes 12-15 are unreachable; if entered, go to FETCH next cycle with all outputs 0.
- reset low, asynchronously: state = FETCH, illegal_op = 0, instr_count = 0.
  - Outputs then take FETCH values, so MemRead = 1.
  - IRWrite = PCWrite = mem_ready, gated to 0 while reset is low.
  - Reset mid-instruction abandons that instruction; it is not counted.
- Output decode is Moore from state. The only exceptions are IRWrite/PCWrite in FETCH, which equal mem_ready. Every signal not listed for a state is 0.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00, IRWrite=PCWrite=mem_ready.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
  - MEM_ADDR and ADDI_EXEC: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - MEM_READ: MemRead=1, IorD=1.
  - MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEM_WRITE: MemWrite=1, IorD=1.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - R_WB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - JUMP: PCWrite=1, PCSource=10.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0.
- Transitions:
  - FETCH -> DECODE when mem_ready = 1; otherwise hold in FETCH with requests held stable.
  - DECODE: R-type -> EXECUTE; lw/sw -> MEM_ADDR; beq -> BRANCH; j -> JUMP; addi -> ADDI_EXEC; illegal -> FETCH and set illegal_op.
  - MEM_ADDR -> MEM_READ if opcode is lw, else MEM_WRITE. opcode is stable because IRWrite only pulses in FETCH.
  - MEM_READ -> MEM_WB on mem_ready; otherwise hold.
  - MEM_WRITE -> FETCH on mem_ready; otherwise hold.
  - EXECUTE -> R_WB; ADDI_EXEC -> ADDI_WB.
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB -> FETCH.
- Instruction latencies with mem_ready tied to 1:
  - lw 5 cycles
  - sw, R-type, addi 4 cycles
  - beq, j 3 cycles
- instr_count increments by 1 on every transition into FETCH from MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB, or from MEM_WRITE with mem_ready = 1.
  - Not incremented on the illegal-opcode path.
  - Wraps modulo 2^CNT_WIDTH.
- illegal_op stays 1 until reset.

Test Plan:
- Reset, mem_ready=1, opcode=000000 -> state_dbg sequence 0,1,6,7,0; RegWrite=1 and RegDst=1 only in state 7; instr_count=1.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> holds state 3 with MemRead=1 and IorD=1 for 4 cycles; then state 4 with RegWrite=1, MemtoReg=1; instr_count increments once.
- sw, then beq, then j back-to-back, mem_ready=1 -> sequences 0,1,2,5 / 0,1,8 / 0,1,9, returning to 0; PCWriteCond=1 only in state 8; PCSource=10 in state 9; instr_count=3.
- FETCH with mem_ready=0 for 5 cycles -> IRWrite=PCWrite=0 and MemRead=1 throughout; IRWrite=1 in exactly the cycle mem_ready rises.
- opcode=111111 -> 0,1,0; illegal_op=1 and stays 1 through subsequent legal instructions; instr_count unchanged.
- Assert reset low asynchronously while in state 4 mid-lw -> state_dbg=0 immediately, RegWrite=0, instr_count=0, illegal_op=0; execution resumes from FETCH after release.
